ex_mem_pipe_stage: RTL and testbench
====================================

# ex_mem_pipe_stage

Parametrised EX→MEM pipeline stage register carrying the execute-stage result bundle (func, op, store data, ALU result, rs2, rd, memory-mux select, write enables) into the memory stage. Unlike a plain enable-gated register bank, it has:

- a valid/ready handshake with optional 2-entry skid buffering, so backpressure never needs a combinational ready path;
- a flush that kills in-flight instructions;
- forwarding-match outputs for the decode/execute hazard logic.

## Interface
Parameters:
- DBITS, 32, data/result width
- REG_INDEX_BIT_WIDTH, 4, register index width
- SKID, 1, 1 = skid buffer present and in_ready is registered; 0 = single register with combinational in_ready

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- flush  in  1  kill all held entries and the current input
- in_valid  in  1  EX bundle valid
- in_ready  out  1  stage can accept this cycle
- in_func, in_op  in  4 each  ALU function / opcode
- in_regData2  in  DBITS  store data
- in_result  in  DBITS  ALU/address result
- in_rs2, in_rd  in  REG_INDEX_BIT_WIDTH each  source 2 / destination index
- in_meMuxSel, in_wrReg, in_wrMem  in  1 each  write-back mux select (1 = memory load) / register write / memory write
- out_valid  out  1  MEM bundle valid
- out_ready  in  1  MEM stage consumes this cycle
- out_func, out_op, out_regData2, out_result, out_rs2, out_rd, out_meMuxSel  out  widths as inputs  held bundle
- out_wrReg, out_wrMem  out  1 each  stored enable AND out_valid
- fwd_rs1, fwd_rs2  in  REG_INDEX_BIT_WIDTH each  decode-stage source indices
- fwd_hit1, fwd_hit2  out  1 each  forwarding match per source
- fwd_data  out  DBITS  equals out_result
- fwd_stall  out  1  load-use hazard

## Operation
- Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
- Main register M always drives out_*. Skid register S exists only when SKID=1.
- SKID=1:
  - in_ready = !S.valid, driven straight from the flop.
  - If M is empty or out_ready: M loads S when S.valid (S empties); otherwise M loads the input when accepting.
  - Else, on accept, the input goes to S.
  - Ordering is strictly FIFO; never drop, never duplicate.
- SKID=0:
  - in_ready = out_ready | !M.valid.
  - M loads on accept.
- M.valid clears on a deliver without a same-cycle load.
- flush (synchronous):
  - clears M.valid and S.valid.
  - An input offered that cycle is discarded even if in_ready=1.
  - Payload flops are untouched.
  - flush has priority over accept and deliver.
- out_wrReg and out_wrMem are gated by out_valid, so killed or empty slots never write.
- Forwarding:
  - fwd_hitN = out_valid & out_wrReg & (out_rd == fwd_rsN); register 0 is not special-cased.
  - fwd_stall = (fwd_hit1 | fwd_hit2) & out_meMuxSel.
  - All forwarding outputs are combinational from M only; S is never visible.

## Timing
- Reset (asynchronous, while low):
  - all valids 0, all payloads 0;
  - out_* = 0, fwd_* = 0;
  - in_ready = 1 (both modes).
- Latency: accept in cycle N → out_valid in cycle N+1.
- Throughput: 1 bundle/cycle while out_ready=1.
- SKID=1 stall: with out_ready low, the stage absorbs exactly 2 bundles. in_ready falls the cycle after S fills and rises the cycle after S drains into M.
- Simultaneous accept and deliver with S empty: M takes the new bundle and out_valid stays 1.
- flush and reset in the same cycle: reset dominates.
- Reset asserted mid-stall: all state is lost and no bundle is emitted after release.
- in_valid may drop while in_ready=0; a bundle is only taken on accept.

## Structure
- Shared package pipe_pkg:
  - DBITS, REG_INDEX_BIT_WIDTH defaults;
  - packed struct ex_bundle_t of {func, op, regData2, result, rs2, rd, meMuxSel, wrReg, wrMem};
  - func/op field width constant 4.
- One sub-module, pipe_skid_slot:
  - holds a valid bit and an ex_bundle_t with load/clear;
  - instantiated once for M, and once for S under SKID=1.
- Forwarding compare is local combinational logic.

## Test plan
- Reset: drive reset low mid-run with M and S full → out_valid=0, out_result=0, in_ready=1 immediately. After release, the first bundle result=0x11 appears 1 cycle after accept.
- Streaming: SKID=1, out_ready=1, bundles result=1..8 back-to-back → out_result 1..8 on consecutive cycles with no bubbles. out_wrReg follows the stored bits.
- Backpressure: out_ready=0 from cycle 2, offer 0xA,0xB,0xC → in_ready=0 after 0xB is held in S. Raise out_ready → outputs 0xA,0xB,0xC in order with no loss.
- Flush: M=0xA, S=0xB, input 0xC with flush=1 → next cycle out_valid=0, out_wrMem=0, in_ready=1. 0xC never appears.
- Forwarding: M holds rd=5, wrReg=1, meMuxSel=0, result=0x1234; fwd_rs1=5, fwd_rs2=3 → fwd_hit1=1, fwd_hit2=0, fwd_data=0x1234, fwd_stall=0. With meMuxSel=1 → fwd_stall=1. With out_valid=0 → all 0.
- SKID=0 build: out_ready=0 with M full → in_ready=0 in the same cycle. A simultaneous deliver and accept keeps out_valid=1 with the new data.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: default widths and
// the execute-stage result bundle layout.
package pipe_pkg;

   localparam int DBITS_DEFAULT     = 32;
   localparam int REG_IDX_W_DEFAULT = 4;
   localparam int FUNC_W            = 4;

   // Bundle at default widths; the stage re-declares it locally when its
   // width parameters differ.
   typedef struct packed {
      logic [FUNC_W-1:0]            func;
      logic [FUNC_W-1:0]            op;
      logic [DBITS_DEFAULT-1:0]     regData2;
      logic [DBITS_DEFAULT-1:0]     result;
      logic [REG_IDX_W_DEFAULT-1:0] rs2;
      logic [REG_IDX_W_DEFAULT-1:0] rd;
      logic                         meMuxSel;
      logic                         wrReg;
      logic                         wrMem;
   } ex_bundle_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One holding slot: a valid bit plus a bundle payload. clear_i only drops
// the valid bit; the payload keeps its last loaded value.
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter type T = ex_bundle_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic clear_i,
   input  T     d_i,
   output logic valid_o,
   output T     q_o
);

   logic valid_q;
   T     data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= d_i;
      end
   end

   assign valid_o = valid_q;
   assign q_o     = data_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM stage register with valid/ready handshake, optional skid slot,
// synchronous flush and forwarding-match outputs taken from the main slot.
module ex_mem_pipe_stage
   import pipe_pkg::*;
#(
   parameter int DBITS               = DBITS_DEFAULT,
   parameter int REG_INDEX_BIT_WIDTH = REG_IDX_W_DEFAULT,
   parameter int SKID                = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [FUNC_W-1:0]              in_func,
   input  logic [FUNC_W-1:0]              in_op,
   input  logic [DBITS-1:0]               in_regData2,
   input  logic [DBITS-1:0]               in_result,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs2,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rd,
   input  logic                           in_meMuxSel,
   input  logic                           in_wrReg,
   input  logic                           in_wrMem,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [FUNC_W-1:0]              out_func,
   output logic [FUNC_W-1:0]              out_op,
   output logic [DBITS-1:0]               out_regData2,
   output logic [DBITS-1:0]               out_result,
   output logic [REG_INDEX_BIT_WIDTH-1:0] out_rs2,
   output logic [REG_INDEX_BIT_WIDTH-1:0] out_rd,
   output logic                           out_meMuxSel,
   output logic                           out_wrReg,
   output logic                           out_wrMem,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] fwd_rs1,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] fwd_rs2,
   output logic                           fwd_hit1,
   output logic                           fwd_hit2,
   output logic [DBITS-1:0]               fwd_data,
   output logic                           fwd_stall
);

   typedef struct packed {
      logic [FUNC_W-1:0]              func;
      logic [FUNC_W-1:0]              op;
      logic [DBITS-1:0]               regData2;
      logic [DBITS-1:0]               result;
      logic [REG_INDEX_BIT_WIDTH-1:0] rs2;
      logic [REG_INDEX_BIT_WIDTH-1:0] rd;
      logic                           meMuxSel;
      logic                           wrReg;
      logic                           wrMem;
   } bundle_t;

   bundle_t in_b;
   bundle_t m_d;
   bundle_t m_q;
   bundle_t s_q;
   logic    m_valid;
   logic    s_valid;
   logic    m_load;
   logic    m_clr;
   logic    s_load;
   logic    s_clr;
   logic    accept;
   logic    deliver;
   logic    m_free;

   always_comb begin
      in_b          = '0;
      in_b.func     = in_func;
      in_b.op       = in_op;
      in_b.regData2 = in_regData2;
      in_b.result   = in_result;
      in_b.rs2      = in_rs2;
      in_b.rd       = in_rd;
      in_b.meMuxSel = in_meMuxSel;
      in_b.wrReg    = in_wrReg;
      in_b.wrMem    = in_wrMem;
   end

   // Handshake: a bundle moves on the input when in_valid & in_ready and
   // leaves on the output when out_valid & out_ready, both sampled at the
   // rising edge; a producer keeps offering until it sees the accept.
   always_comb begin
      accept  = in_valid & in_ready;
      deliver = out_valid & out_ready;
      m_free  = !m_valid | out_ready;
      m_load  = 1'b0;
      s_load  = 1'b0;
      s_clr   = flush;
      m_d     = in_b;
      if (!flush) begin
         if (m_free && s_valid) begin
            // The older skid entry goes first to keep FIFO order.
            m_load = 1'b1;
            m_d    = s_q;
            s_clr  = 1'b1;
         end else if (m_free) begin
            m_load = accept;
         end else begin
            s_load = accept;
         end
      end
      m_clr = flush | (deliver & !m_load);
   end

   pipe_skid_slot #(.T(bundle_t)) u_main (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (m_load),
      .clear_i (m_clr),
      .d_i     (m_d),
      .valid_o (m_valid),
      .q_o     (m_q)
   );

   if (SKID != 0) begin : g_skid
      pipe_skid_slot #(.T(bundle_t)) u_skid (
         .clk     (clk),
         .rst_n   (reset),
         .load_i  (s_load),
         .clear_i (s_clr),
         .d_i     (in_b),
         .valid_o (s_valid),
         .q_o     (s_q)
      );
      assign in_ready = !s_valid;
   end else begin : g_noskid
      assign s_valid  = 1'b0;
      assign s_q      = '0;
      assign in_ready = out_ready | !m_valid;
   end

   assign out_valid    = m_valid;
   assign out_func     = m_q.func;
   assign out_op       = m_q.op;
   assign out_regData2 = m_q.regData2;
   assign out_result   = m_q.result;
   assign out_rs2      = m_q.rs2;
   assign out_rd       = m_q.rd;
   assign out_meMuxSel = m_q.meMuxSel;
   assign out_wrReg    = m_q.wrReg & m_valid;
   assign out_wrMem    = m_q.wrMem & m_valid;

   // Register 0 is deliberately not special-cased in the match.
   assign fwd_hit1  = out_wrReg & (out_rd == fwd_rs1);
   assign fwd_hit2  = out_wrReg & (out_rd == fwd_rs2);
   assign fwd_data  = out_result;
   assign fwd_stall = (fwd_hit1 | fwd_hit2) & out_meMuxSel;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: a SKID=1 instance driven from a
// vector table plus hand sequences, and a SKID=0 instance for its own cases.
module tb_ex_mem_pipe_stage;

   localparam int  DW = 32;
   localparam int  RW = 4;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam int  NV = 25;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // shared payload inputs
   logic [3:0]    in_func, in_op;
   logic [DW-1:0] in_regData2;
   logic [RW-1:0] in_rs2, in_rd, fwd_rs1, fwd_rs2;
   logic          in_meMuxSel, in_wrReg, in_wrMem;

   // SKID=1 instance
   logic          flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_result, out_regData2, out_result, fwd_data;
   logic [3:0]    out_func, out_op;
   logic [RW-1:0] out_rs2, out_rd;
   logic          out_meMuxSel, out_wrReg, out_wrMem;
   logic          fwd_hit1, fwd_hit2, fwd_stall;

   // SKID=0 instance
   logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [DW-1:0] b_in_result, b_out_regData2, b_out_result, b_fwd_data;
   logic [3:0]    b_out_func, b_out_op;
   logic [RW-1:0] b_out_rs2, b_out_rd;
   logic          b_out_meMuxSel, b_out_wrReg, b_out_wrMem;
   logic          b_fwd_hit1, b_fwd_hit2, b_fwd_stall;

   ex_mem_pipe_stage #(.DBITS(DW), .REG_INDEX_BIT_WIDTH(RW), .SKID(1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_func(in_func), .in_op(in_op), .in_regData2(in_regData2),
      .in_result(in_result), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_meMuxSel(in_meMuxSel), .in_wrReg(in_wrReg), .in_wrMem(in_wrMem),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_func(out_func), .out_op(out_op), .out_regData2(out_regData2),
      .out_result(out_result), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_meMuxSel(out_meMuxSel), .out_wrReg(out_wrReg), .out_wrMem(out_wrMem),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1),
      .fwd_hit2(fwd_hit2), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
   );

   ex_mem_pipe_stage #(.DBITS(DW), .REG_INDEX_BIT_WIDTH(RW), .SKID(0)) dut0 (
      .clk(clk), .reset(reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_func(in_func), .in_op(in_op), .in_regData2(in_regData2),
      .in_result(b_in_result), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_meMuxSel(in_meMuxSel), .in_wrReg(in_wrReg), .in_wrMem(in_wrMem),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_func(b_out_func), .out_op(b_out_op), .out_regData2(b_out_regData2),
      .out_result(b_out_result), .out_rs2(b_out_rs2), .out_rd(b_out_rd),
      .out_meMuxSel(b_out_meMuxSel), .out_wrReg(b_out_wrReg), .out_wrMem(b_out_wrMem),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(b_fwd_hit1),
      .fwd_hit2(b_fwd_hit2), .fwd_data(b_fwd_data), .fwd_stall(b_fwd_stall)
   );

   typedef struct {
      logic        iv, ord, fl, wr;
      logic [31:0] res;
      logic        ev;
      logic [31:0] eres;
      logic        eir, ewr;
   } vec_t;

   vec_t tbl[NV];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // stream 1..8, drain, backpressure A/B/C, flush with M=A S=B, flush of an acceptable input
      tbl[0]  = '{H, H, L, H, 32'h1, L, 32'h0, H, L};
      tbl[1]  = '{H, H, L, L, 32'h2, H, 32'h1, H, H};
      tbl[2]  = '{H, H, L, H, 32'h3, H, 32'h2, H, L};
      tbl[3]  = '{H, H, L, L, 32'h4, H, 32'h3, H, H};
      tbl[4]  = '{H, H, L, H, 32'h5, H, 32'h4, H, L};
      tbl[5]  = '{H, H, L, L, 32'h6, H, 32'h5, H, H};
      tbl[6]  = '{H, H, L, H, 32'h7, H, 32'h6, H, L};
      tbl[7]  = '{H, H, L, L, 32'h8, H, 32'h7, H, H};
      tbl[8]  = '{L, H, L, L, 32'h0, H, 32'h8, H, L};
      tbl[9]  = '{L, H, L, L, 32'h0, L, 32'h8, H, L};
      tbl[10] = '{H, H, L, H, 32'hA, L, 32'h8, H, L};
      tbl[11] = '{H, L, L, H, 32'hB, H, 32'hA, H, H};
      tbl[12] = '{H, L, L, L, 32'hC, H, 32'hA, L, H};
      tbl[13] = '{H, L, L, L, 32'hC, H, 32'hA, L, H};
      tbl[14] = '{H, H, L, L, 32'hC, H, 32'hA, L, H};
      tbl[15] = '{H, H, L, L, 32'hC, H, 32'hB, H, H};
      tbl[16] = '{L, H, L, L, 32'h0, H, 32'hC, H, L};
      tbl[17] = '{L, H, L, L, 32'h0, L, 32'hC, H, L};
      tbl[18] = '{H, L, L, H, 32'hA, L, 32'hC, H, L};
      tbl[19] = '{H, L, L, H, 32'hB, H, 32'hA, H, H};
      tbl[20] = '{H, L, H, L, 32'hC, H, 32'hA, L, H};
      tbl[21] = '{L, H, L, L, 32'h0, L, 32'hA, H, L};
      tbl[22] = '{L, H, L, L, 32'h0, L, 32'hA, H, L};
      tbl[23] = '{H, H, H, H, 32'hD, L, 32'hA, H, L};
      tbl[24] = '{L, H, L, L, 32'h0, L, 32'hA, H, L};

      // clock/reset
      reset = 1'b0;
      in_func = 4'h3; in_op = 4'h9; in_regData2 = 32'h55AA; in_rs2 = 4'd2;
      in_rd = 4'd0; in_meMuxSel = 1'b0; in_wrReg = 1'b1; in_wrMem = 1'b1;
      fwd_rs1 = 4'd0; fwd_rs2 = 4'd0;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_result = '0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_result = '0;
      #2;
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset out_result", out_result, 32'h0);
      check("reset in_ready", 32'(in_ready), 32'h1);
      check("reset out_wrReg", 32'(out_wrReg), 32'h0);
      check("reset fwd_hit1", 32'(fwd_hit1), 32'h0);
      check("reset fwd_stall", 32'(fwd_stall), 32'h0);
      check("reset fwd_data", fwd_data, 32'h0);
      check("reset skid0 in_ready", 32'(b_in_ready), 32'h1);
      @(negedge clk);
      reset = 1'b1;

      // table-driven vectors on the SKID=1 instance
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_valid  = tbl[i].iv;
         out_ready = tbl[i].ord;
         flush     = tbl[i].fl;
         in_result = tbl[i].res;
         in_wrReg  = tbl[i].wr;
         in_wrMem  = tbl[i].wr;
         #1;
         check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         check($sformatf("row%0d out_result", i), out_result, tbl[i].eres);
         check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
         check($sformatf("row%0d out_wrReg", i), 32'(out_wrReg), 32'(tbl[i].ewr));
         check($sformatf("row%0d out_wrMem", i), 32'(out_wrMem), 32'(tbl[i].ewr));
      end
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

      // forwarding
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0; in_result = 32'h1234; in_rd = 4'd5;
      in_wrReg = 1'b1; in_wrMem = 1'b0; in_meMuxSel = 1'b0; fwd_rs1 = 4'd5; fwd_rs2 = 4'd3;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("fwd hit1", 32'(fwd_hit1), 32'h1);
      check("fwd hit2", 32'(fwd_hit2), 32'h0);
      check("fwd data", fwd_data, 32'h1234);
      check("fwd stall alu", 32'(fwd_stall), 32'h0);
      fwd_rs2 = 4'd5;
      #1;
      check("fwd hit2 both", 32'(fwd_hit2), 32'h1);
      in_valid = 1'b1; out_ready = 1'b1; in_meMuxSel = 1'b1; in_result = 32'h5678;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("fwd stall load", 32'(fwd_stall), 32'h1);
      check("fwd data load", fwd_data, 32'h5678);
      fwd_rs1 = 4'd6; fwd_rs2 = 4'd6;
      #1;
      check("fwd no match hit1", 32'(fwd_hit1), 32'h0);
      check("fwd no match stall", 32'(fwd_stall), 32'h0);
      fwd_rs1 = 4'd5; fwd_rs2 = 4'd5;
      @(negedge clk);
      #1;
      check("fwd empty hit1", 32'(fwd_hit1), 32'h0);
      check("fwd empty hit2", 32'(fwd_hit2), 32'h0);
      check("fwd empty stall", 32'(fwd_stall), 32'h0);

      // reset asserted with both slots full
      in_meMuxSel = 1'b0; in_wrMem = 1'b1; in_rd = 4'd1;
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0; in_result = 32'h21;
      @(negedge clk);
      in_result = 32'h22;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("stall full in_ready", 32'(in_ready), 32'h0);
      check("stall full out_result", out_result, 32'h21);
      reset = 1'b0;
      #1;
      check("async reset out_valid", 32'(out_valid), 32'h0);
      check("async reset out_result", out_result, 32'h0);
      check("async reset in_ready", 32'(in_ready), 32'h1);
      check("async reset out_wrMem", 32'(out_wrMem), 32'h0);
      @(negedge clk);
      reset = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("post reset idle%0d out_valid", k), 32'(out_valid), 32'h0);
      end
      in_valid = 1'b1; in_result = 32'h11;
      #1;
      check("post reset accept cycle out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("post reset first out_valid", 32'(out_valid), 32'h1);
      check("post reset first out_result", out_result, 32'h11);
      out_ready = 1'b0;

      // SKID=0 instance
      @(negedge clk);
      b_in_valid = 1'b1; b_out_ready = 1'b0; b_in_result = 32'h31;
      #1;
      check("skid0 empty in_ready", 32'(b_in_ready), 32'h1);
      @(negedge clk);
      b_in_result = 32'h32;
      #1;
      check("skid0 full in_ready", 32'(b_in_ready), 32'h0);
      check("skid0 full out_result", b_out_result, 32'h31);
      b_out_ready = 1'b1;
      #1;
      check("skid0 ready follows out_ready", 32'(b_in_ready), 32'h1);
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      check("skid0 swap out_valid", 32'(b_out_valid), 32'h1);
      check("skid0 swap out_result", b_out_result, 32'h32);
      @(negedge clk);
      b_out_ready = 1'b0;
      #1;
      check("skid0 drained out_valid", 32'(b_out_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
